// File: rtl/tile_spawner.sv
// Captures the post-move board and drops one 2/4 tile into a pseudo-random empty cell.
// Also builds the opening board: clear, then two spawns.
//
// state    | meaning
// S_IDLE   | waiting for start / new_game
// S_LOAD   | compare captured board with held board, load it if it differs
// S_COUNT  | 16-cycle scan counting empty cells, then draw k and tile value
// S_REDUCE | fold k into 0..empty_cnt-1, one subtraction per cycle
// S_WRITE  | scan to the k-th empty cell and write the tile there
// S_DONE   | one-cycle done pulse, refresh full flag
module tile_spawner #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter bit          SKIP_NOMOVE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         new_game,
    input  logic [191:0] board_in,
    output logic [191:0] board,
    output logic         busy,
    output logic         done,
    output logic         spawned,
    output logic         full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_REDUCE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [191:0]   board_q, board_d;
    logic [191:0]   tmp_q, tmp_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [3:0]     idx_q, idx_d;
    logic [4:0]     empty_q, empty_d;
    logic [3:0]     seen_q, seen_d;
    logic [3:0]     k_q, k_d;
    logic           four_q, four_d;
    logic [1:0]     spawn_left_q, spawn_left_d;
    logic           hit_q, hit_d;
    logic           busy_q, busy_d;
    logic           spawned_q, spawned_d;
    logic           full_q, full_d;

    logic [15:0]    zero_vec;
    logic [4:0]     empty_next;
    logic [11:0]    tile_val;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            zero_vec[i] = (board_q[12*i +: 12] == 12'd0);
        end
    end

    assign empty_next = empty_q + {4'b0000, zero_vec[idx_q]};
    assign tile_val   = four_q ? 12'd4 : 12'd2;

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        tmp_d        = tmp_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d        = idx_q;
        empty_d      = empty_q;
        seen_d       = seen_q;
        k_d          = k_q;
        four_d       = four_q;
        spawn_left_d = spawn_left_q;
        hit_d        = hit_q;
        busy_d       = busy_q;
        spawned_d    = spawned_q;
        full_d       = full_q;

        case (state_q)
            S_IDLE: begin
                if (new_game) begin
                    board_d      = '0;
                    spawn_left_d = 2'd2;
                    hit_d        = 1'b0;
                    idx_d        = 4'd0;
                    empty_d      = 5'd0;
                    busy_d       = 1'b1;
                    state_d      = S_COUNT;
                end else if (start) begin
                    tmp_d   = board_in;
                    hit_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (SKIP_NOMOVE && (tmp_q == board_q)) begin
                    spawned_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    board_d      = tmp_q;
                    spawn_left_d = 2'd1;
                    idx_d        = 4'd0;
                    empty_d      = 5'd0;
                    state_d      = S_COUNT;
                end
            end
            S_COUNT: begin
                empty_d = empty_next;
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    if (empty_next == 5'd0) begin
                        spawned_d = hit_q;
                        state_d   = S_DONE;
                    end else begin
                        k_d    = lfsr_q[3:0];
                        four_d = (lfsr_q[11:8] == 4'd0);
                        idx_d  = 4'd0;
                        seen_d = 4'd0;
                        // skip REDUCE entirely when the draw already lands in range
                        state_d = ({1'b0, lfsr_q[3:0]} < empty_next) ? S_WRITE : S_REDUCE;
                    end
                end
            end
            S_REDUCE: begin
                // k >= empty_cnt implies empty_cnt <= 15, so its low nibble is exact
                if ({1'b0, k_q} >= empty_q) begin
                    k_d = k_q - empty_q[3:0];
                end else begin
                    idx_d   = 4'd0;
                    seen_d  = 4'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 4'd1;
                if (zero_vec[idx_q]) begin
                    if (seen_q == k_q) begin
                        for (int i = 0; i < 16; i++) begin
                            if (idx_q == 4'(i)) begin
                                board_d[12*i +: 12] = tile_val;
                            end
                        end
                        hit_d        = 1'b1;
                        spawn_left_d = spawn_left_q - 2'd1;
                        if (spawn_left_q == 2'd1) begin
                            spawned_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            idx_d   = 4'd0;
                            empty_d = 5'd0;
                            state_d = S_COUNT;
                        end
                    end else begin
                        seen_d = seen_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                full_d  = ~|zero_vec;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            tmp_q        <= '0;
            lfsr_q       <= SEED;
            idx_q        <= 4'd0;
            empty_q      <= 5'd0;
            seen_q       <= 4'd0;
            k_q          <= 4'd0;
            four_q       <= 1'b0;
            spawn_left_q <= 2'd0;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
            spawned_q    <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            tmp_q        <= tmp_d;
            lfsr_q       <= lfsr_d;
            idx_q        <= idx_d;
            empty_q      <= empty_d;
            seen_q       <= seen_d;
            k_q          <= k_d;
            four_q       <= four_d;
            spawn_left_q <= spawn_left_d;
            hit_q        <= hit_d;
            busy_q       <= busy_d;
            spawned_q    <= spawned_d;
            full_q       <= full_d;
        end
    end

    assign board   = board_q;
    assign busy    = busy_q;
    assign done    = (state_q == S_DONE);
    assign spawned = spawned_q;
    assign full    = full_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Bench for tile_spawner: vector table of commands with a scoreboard of expected
// outcomes, plus hand sequences for mid-run reset and overlapping commands.
module tb_tile_spawner;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         new_game = 1'b0;
    logic [191:0] board_in = '0;
    logic [191:0] board;
    logic         busy, done, spawned, full;

    always #5 clk = ~clk;

    tile_spawner #(.SEED(16'hACE1), .SKIP_NOMOVE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .new_game(new_game),
        .board_in(board_in), .board(board), .busy(busy), .done(done),
        .spawned(spawned), .full(full)
    );

    typedef struct {
        bit          is_new;
        logic [15:0] zmask;
        bit          exp_spawned;
        bit          exp_full;
        int          exp_lat;
        int          n_new;
        int          hit_cell;
    } vec_t;

    typedef struct {
        bit           spawned;
        bit           full;
        int           lat;
        int           bound;
        logic [191:0] ref_board;
        int           n_new;
        int           hit_cell;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // cell i gets a distinct nonzero value unless its mask bit marks it empty
    function automatic logic [191:0] pat(logic [15:0] zmask);
        logic [191:0] b;
        for (int i = 0; i < 16; i++) b[12*i +: 12] = zmask[i] ? 12'd0 : 12'(16*i + 3);
        return b;
    endfunction

    task automatic send(bit is_new, bit is_start, logic [191:0] bin);
        @(negedge clk);
        board_in = bin;
        start    = is_start;
        new_game = is_new;
        @(posedge clk);
        #1;
        start    = 1'b0;
        new_game = 1'b0;
    endtask

    task automatic wait_done(int bound, output int lat);
        lat = 1;
        while (!done && lat < bound + 5) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic push_exp(bit sp, bit fl, int lat, int bound, logic [191:0] rb, int nn, int hc);
        exp_t e;
        e.spawned = sp; e.full = fl; e.lat = lat; e.bound = bound;
        e.ref_board = rb; e.n_new = nn; e.hit_cell = hc;
        exp_q.push_back(e);
    endtask

    task automatic finish_check(string tag, int lat);
        exp_t e;
        int chg, bad;
        logic [11:0] a, r;
        e = exp_q.pop_front();
        chk({tag, "_done_seen"}, int'(done), 1);
        if (e.lat > 0) chk({tag, "_latency"}, lat, e.lat);
        else           chk({tag, "_latency_bound"}, int'(lat <= e.bound), 1);
        chk({tag, "_spawned"}, int'(spawned), int'(e.spawned));
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_cleared"}, int'(busy), 0);
        chk({tag, "_full"}, int'(full), int'(e.full));
        chg = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            a = board[12*i +: 12];
            r = e.ref_board[12*i +: 12];
            if (a != r) begin
                chg++;
                if (r != 12'd0 || !(a == 12'd2 || a == 12'd4)) bad++;
                if (e.hit_cell >= 0 && i != e.hit_cell) bad++;
            end
        end
        chk({tag, "_changed_cells"}, chg, e.n_new);
        chk({tag, "_changed_valid"}, bad, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int lat, wait_n, ndone;
        string tag;

        vecs[0] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 0,  2, -1};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 18, 0, -1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2,  0, -1};
        vecs[3] = '{1'b0, 16'h0200, 1'b1, 1'b1, 0,  1, 9};
        vecs[4] = '{1'b0, 16'h5555, 1'b1, 1'b0, 0,  1, -1};
        vecs[5] = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 0,  1, -1};
        vecs[6] = '{1'b0, 16'h8000, 1'b1, 1'b1, 0,  1, 15};
        vecs[7] = '{1'b0, 16'h0001, 1'b1, 1'b1, 0,  1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_board_zero", int'(board != '0), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_spawned", int'(spawned), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_lfsr", int'(dut.lfsr_q), 16'hACE1);
        @(negedge clk);
        rst = 1'b1;

        // reset in the middle of the COUNT scan of a loaded board
        send(1'b0, 1'b1, pat(16'h0200));
        chk("midrst_busy_before", int'(busy), 1);
        wait_n = $urandom_range(3, 14);
        repeat (wait_n) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_board_zero", int'(board != '0), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("vec%0d", v);
            if (vecs[v].is_new)
                push_exp(vecs[v].exp_spawned, vecs[v].exp_full, vecs[v].exp_lat, 96,
                         '0, vecs[v].n_new, vecs[v].hit_cell);
            else
                push_exp(vecs[v].exp_spawned, vecs[v].exp_full, vecs[v].exp_lat, 49,
                         pat(vecs[v].zmask), vecs[v].n_new, vecs[v].hit_cell);
            send(vecs[v].is_new, !vecs[v].is_new, pat(vecs[v].zmask));
            chk({tag, "_busy_after_accept"}, int'(busy), 1);
            wait_done(vecs[v].is_new ? 96 : 49, lat);
            finish_check(tag, lat);
        end

        // second start while busy must be ignored
        push_exp(1'b1, 1'b1, 0, 49, pat(16'h0010), 1, 4);
        send(1'b0, 1'b1, pat(16'h0010));
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 6) begin
                board_in = pat(16'h0000);
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        finish_check("busy_start", lat);
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("busy_start_no_rerun", ndone, 0);

        // start and new_game together: new_game wins even with a full board_in
        push_exp(1'b1, 1'b0, 0, 96, '0, 2, -1);
        send(1'b1, 1'b1, pat(16'h0000));
        wait_done(96, lat);
        finish_check("both_cmds", lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
